// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
// FSM state encoding, AXI response codes and the full-word write strobe.
package axi4_lite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        DONE         = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

endpackage

// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite channel bundle between the arbiter (master) and the register bank (slave).
// Every channel transfers on a cycle where valid and ready are both high; a valid,
// once raised, stays high with stable payload until that transfer cycle.
interface axi4_lite_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_arbiter_rr_arbiter.sv
// Round-robin picker: searches upward from (last_grant + 1) mod NUM_REQ.
// The last_grant pointer only moves when the owning transaction completes.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update_en,
    input  logic [IDX_W-1:0]   i_update_idx,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);
    logic [IDX_W-1:0] r_last_grant;
    int               w_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= '0;
        end else if (i_update_en) begin
            r_last_grant <= i_update_idx;
        end
    end

    always_comb begin
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cand   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = (int'(r_last_grant) + i) % NUM_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(w_cand);
            end
        end
        if (o_any) begin
            o_onehot[o_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ req/done requesters, one transaction at a time.
// Optional AXI_LITE_ARB_RANGE_CHECK_EN: out-of-bank or misaligned addresses complete locally with DECERR.
module axi4_lite_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [1:0]                rsp_resp,
    output state_t                    o_dbg_state,
    axi4_lite_arbiter_if.master       m_axi
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if ((NUM_REQ < 1) || (NUM_REQ > 8) || (DATA_W != 32) || (NUM_REGS < 1)) begin : g_param_err
        $error("axi4_lite_arbiter: unsupported parameter set");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_done;
    logic                r_w_done;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [1:0]          r_rsp_resp;

    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_addr_bad;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_rr_update;

    assign w_rr_update = (r_state == DONE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk          (aclk),
        .rst_n        (aresetn),
        .i_req        (req),
        .i_update_en  (w_rr_update),
        .i_update_idx (r_idx),
        .o_any        (w_any),
        .o_idx        (w_pick),
        .o_onehot     (w_pick_onehot)
    );

    assign w_sel_we    = req_we[w_pick];
    assign w_sel_addr  = req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[int'(w_pick)*DATA_W +: DATA_W];

`ifdef AXI_LITE_ARB_RANGE_CHECK_EN
    assign w_addr_bad = (w_sel_addr[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS)) ||
                        (w_sel_addr[1:0] != 2'b00);
`else
    assign w_addr_bad = 1'b0;
`endif

    // Valids are decoded from registered state so reset drops them immediately.
    assign m_axi.awvalid = (r_state == WR_ADDR_DATA) && !r_aw_done;
    assign m_axi.wvalid  = (r_state == WR_ADDR_DATA) && !r_w_done;
    assign m_axi.bready  = (r_state == WR_RESP);
    assign m_axi.arvalid = (r_state == RD_ADDR);
    assign m_axi.rready  = (r_state == RD_DATA);
    assign m_axi.awaddr  = r_addr;
    assign m_axi.araddr  = r_addr;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = WSTRB_ALL;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;

    assign w_aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_w_hs  = m_axi.wvalid && m_axi.wready;

    assign gnt         = r_gnt;
    assign done        = (r_state == DONE) ? r_gnt : '0;
    assign rsp_data    = r_rsp_data;
    assign rsp_resp    = r_rsp_resp;
    assign o_dbg_state = r_state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (w_addr_bad)    w_next_state = DONE;
                    else if (w_sel_we) w_next_state = WR_ADDR_DATA;
                    else               w_next_state = RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next_state = WR_RESP;
            end
            WR_RESP:  if (m_axi.bvalid)  w_next_state = DONE;
            RD_ADDR:  if (m_axi.arready) w_next_state = RD_DATA;
            RD_DATA:  if (m_axi.rvalid)  w_next_state = DONE;
            DONE:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx      <= '0;
            r_gnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_resp <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx     <= w_pick;
                        r_gnt     <= w_pick_onehot;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (w_addr_bad) begin
                            r_rsp_data <= '0;
                            r_rsp_resp <= RESP_DECERR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        r_rsp_data <= '0;
                        r_rsp_resp <= m_axi.bresp;
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        r_rsp_data <= m_axi.rdata;
                        r_rsp_resp <= m_axi.rresp;
                    end
                end
                DONE:    r_gnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: vector table of single transactions against a small
// register-bank slave model, plus contention and reset-during-read sequences.
module tb_axi4_lite_arbiter;
    import axi4_lite_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [1:0]  req, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  gnt, done;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    state_t      dbg_state;

    axi4_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_axi ();

    axi4_lite_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .o_dbg_state (dbg_state),
        .m_axi       (m_axi)
    );

    // ---------------- register-bank slave model ----------------
    logic [31:0] mem [0:15];
    int          aw_wait = 0;
    int          w_wait  = 0;
    logic        r_hold  = 1'b0;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got, r_pend;
    logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
    logic [31:0] aw_addr_eff, w_data_eff;
    logic        s_aw_hs, s_w_hs, s_ar_hs;

    assign m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_wait);
    assign m_axi.wready  = m_axi.wvalid && (w_cnt >= w_wait);
    assign m_axi.arready = m_axi.arvalid;
    assign s_aw_hs       = m_axi.awvalid && m_axi.awready;
    assign s_w_hs        = m_axi.wvalid && m_axi.wready;
    assign s_ar_hs       = m_axi.arvalid && m_axi.arready;
    assign aw_addr_eff   = s_aw_hs ? m_axi.awaddr : aw_addr_q;
    assign w_data_eff    = s_w_hs ? m_axi.wdata : w_data_q;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; ar_addr_q <= '0;
            m_axi.bvalid <= 1'b0; m_axi.bresp <= 2'b00;
            m_axi.rvalid <= 1'b0; m_axi.rresp <= 2'b00; m_axi.rdata <= '0;
        end else begin
            aw_cnt <= (m_axi.awvalid && !m_axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi.wvalid && !m_axi.wready) ? w_cnt + 1 : 0;
            if (s_aw_hs) begin aw_got <= 1'b1; aw_addr_q <= m_axi.awaddr; end
            if (s_w_hs)  begin w_got <= 1'b1; w_data_q <= m_axi.wdata; end
            if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                m_axi.bvalid <= 1'b1;
                if (aw_addr_eff >= 32'h40) begin
                    m_axi.bresp <= RESP_SLVERR;
                end else begin
                    m_axi.bresp <= RESP_OKAY;
                    mem[aw_addr_eff[5:2]] <= w_data_eff;
                end
            end
            if (m_axi.rvalid && m_axi.rready) m_axi.rvalid <= 1'b0;
            if (s_ar_hs) ar_addr_q <= m_axi.araddr;
            if ((s_ar_hs || r_pend) && !r_hold) begin
                r_pend <= 1'b0;
                m_axi.rvalid <= 1'b1;
                if ((s_ar_hs ? m_axi.araddr : ar_addr_q) >= 32'h40) begin
                    m_axi.rresp <= RESP_SLVERR;
                    m_axi.rdata <= '0;
                end else begin
                    m_axi.rresp <= RESP_OKAY;
                    m_axi.rdata <= mem[s_ar_hs ? m_axi.araddr[5:2] : ar_addr_q[5:2]];
                end
            end else if (s_ar_hs) begin
                r_pend <= 1'b1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs = 0, gnt_multi = 0, done_pulses = 0;
    always @(negedge aclk) begin
        aw_cyc <= aw_cyc + int'(m_axi.awvalid);
        w_cyc  <= w_cyc + int'(m_axi.wvalid);
        ar_cyc <= ar_cyc + int'(m_axi.arvalid);
        b_hs   <= b_hs + int'(m_axi.bvalid && m_axi.bready);
        if ($countones(gnt) > 1) gnt_multi <= gnt_multi + 1;
        if (|done) done_pulses <= done_pulses + 1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    int txn_count = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input int idx, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] e_resp,
                           input logic [31:0] e_data, input string tag, output int lat);
        bit found;
        logic [33:0] e;
        found = 1'b0;
        lat = -1;
        txn_count++;
        exp_q.push_back({e_resp, e_data});
        req_we[idx] = we;
        req_addr[idx*32 +: 32] = addr;
        req_wdata[idx*32 +: 32] = wdata;
        req[idx] = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge aclk);
            if (done[idx]) begin
                found = 1'b1;
                lat = c + 1;
                check({tag, "_gnt"}, 64'(gnt), 64'(1) << idx);
                e = exp_q.pop_front();
                check({tag, "_rsp"}, 64'({rsp_resp, rsp_data}), 64'(e));
            end
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
        @(posedge aclk); #1;
        req[idx] = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_w;
        int          w_w;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
    } vec_t;

    function automatic vec_t mk(int idx, logic we, logic [31:0] addr, logic [31:0] wdata,
                                int aw_w, int w_w, int lat, logic [1:0] resp, logic [31:0] data,
                                int n_aw, int n_w, int n_ar);
        vec_t v;
        v.idx = idx; v.we = we; v.addr = addr; v.wdata = wdata;
        v.aw_w = aw_w; v.w_w = w_w; v.exp_lat = lat; v.exp_resp = resp; v.exp_data = data;
        v.exp_aw = n_aw; v.exp_w = n_w; v.exp_ar = n_ar;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, a0, w0, r0, b0, p0;
        bit found;
        logic [1:0]  exp_done [4];
        logic [33:0] e;

        vecs[0] = mk(0, 1'b1, 32'h08, 32'hA5A5_0001, 0, 0, 4, RESP_OKAY, 32'h0, 1, 1, 0);
        vecs[1] = mk(0, 1'b1, 32'h10, 32'h0000_1234, 0, 0, 4, RESP_OKAY, 32'h0, 1, 1, 0);
        vecs[2] = mk(0, 1'b0, 32'h10, 32'h0,         0, 0, 4, RESP_OKAY, 32'h0000_1234, 0, 0, 1);
        vecs[3] = mk(0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 3, 0, 7, RESP_OKAY, 32'h0, 4, 1, 0);
        vecs[4] = mk(1, 1'b1, 32'h04, 32'hCAFE_0004, 0, 2, 6, RESP_OKAY, 32'h0, 1, 3, 0);
        vecs[5] = mk(1, 1'b0, 32'h0C, 32'h0,         0, 0, 4, RESP_OKAY, 32'hDEAD_BEEF, 0, 0, 1);
        vecs[6] = mk(1, 1'b1, 32'h3C, 32'h0F0F_0F0F, 1, 1, 5, RESP_OKAY, 32'h0, 2, 2, 0);
        vecs[7] = mk(0, 1'b0, 32'h3C, 32'h0,         0, 0, 4, RESP_OKAY, 32'h0F0F_0F0F, 0, 0, 1);
`ifdef AXI_LITE_ARB_RANGE_CHECK_EN
        vecs[8] = mk(0, 1'b0, 32'h40, 32'h0,         0, 0, 2, RESP_DECERR, 32'h0, 0, 0, 0);
        vecs[9] = mk(1, 1'b0, 32'h06, 32'h0,         0, 0, 2, RESP_DECERR, 32'h0, 0, 0, 0);
`else
        vecs[8] = mk(0, 1'b0, 32'h40, 32'h0,         0, 0, 4, RESP_SLVERR, 32'h0, 0, 0, 1);
        vecs[9] = mk(1, 1'b0, 32'h06, 32'h0,         0, 0, 4, RESP_OKAY, 32'hCAFE_0004, 0, 0, 1);
`endif

        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // reset state
        repeat (3) @(negedge aclk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valids", 64'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}), 64'd0);
        check("rst_rsp", 64'({rsp_resp, rsp_data}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // vector table
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            aw_wait = vecs[i].aw_w;
            w_wait  = vecs[i].w_w;
            a0 = aw_cyc; w0 = w_cyc; r0 = ar_cyc; b0 = b_hs;
            run_txn(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_resp, vecs[i].exp_data, tag, lat);
            check({tag, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
            check({tag, "_aw_cycles"}, 64'(aw_cyc - a0), 64'(vecs[i].exp_aw));
            check({tag, "_w_cycles"}, 64'(w_cyc - w0), 64'(vecs[i].exp_w));
            check({tag, "_ar_cycles"}, 64'(ar_cyc - r0), 64'(vecs[i].exp_ar));
            check({tag, "_b_handshakes"}, 64'(b_hs - b0), 64'(vecs[i].exp_aw != 0 ? 1 : 0));
        end
        aw_wait = 0;
        w_wait = 0;

        // contention from pointer 0: expect 1,0,1,0
        @(negedge aclk); aresetn = 1'b0;
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        exp_done[0] = 2'b10; exp_done[1] = 2'b01; exp_done[2] = 2'b10; exp_done[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({RESP_OKAY, (k % 2 == 0) ? 32'h0 : 32'h55AA_55AA});
            txn_count++;
        end
        req_we = 2'b10;
        req_addr = {32'h20, 32'h20};
        req_wdata = {32'h55AA_55AA, 32'h0};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 30 && !found; c++) begin
                @(negedge aclk);
                if (|done) begin
                    found = 1'b1;
                    check($sformatf("rr%0d_done", k), 64'(done), 64'(exp_done[k]));
                    check($sformatf("rr%0d_gnt", k), 64'(gnt), 64'(exp_done[k]));
                    e = exp_q.pop_front();
                    check($sformatf("rr%0d_rsp", k), 64'({rsp_resp, rsp_data}), 64'(e));
                end
            end
            check($sformatf("rr%0d_done_seen", k), 64'(found), 64'd1);
        end
        @(posedge aclk); #1;
        req = 2'b00;
        repeat (2) @(posedge aclk);
        #1;

        // reset while waiting for read data
        r_hold = 1'b1;
        req_we[0] = 1'b0;
        req_addr[31:0] = 32'h10;
        req[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge aclk);
            if (dbg_state == RD_DATA) found = 1'b1;
        end
        check("mid_rd_reached", 64'(found), 64'd1);
        check("mid_rd_rready", 64'(m_axi.rready), 64'd1);
        p0 = done_pulses;
        aresetn = 1'b0;
        #1;
        check("rst_rd_rready", 64'(m_axi.rready), 64'd0);
        check("rst_rd_arvalid", 64'(m_axi.arvalid), 64'd0);
        check("rst_rd_gnt", 64'(gnt), 64'd0);
        check("rst_rd_state", 64'(dbg_state), 64'(IDLE));
        req[0] = 1'b0;
        repeat (2) @(negedge aclk);
        r_hold = 1'b0;
        aresetn = 1'b1;
        repeat (8) @(negedge aclk);
        check("rst_rd_no_done", 64'(done_pulses - p0), 64'd0);
        check("rst_rd_state_after", 64'(dbg_state), 64'(IDLE));
        check("rst_rd_rsp_cleared", 64'({rsp_resp, rsp_data}), 64'd0);
        @(posedge aclk); #1;

        // global checks
        check("gnt_onehot", 64'(gnt_multi), 64'd0);
        check("done_pulse_count", 64'(done_pulses), 64'(txn_count));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
